// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midi_pkg
//  Description : Shared constants, types and the note-to-ticks formula for
//                the MIDI note controller.
//  Revision    : 1.0  initial release
// ============================================================================
package midi_pkg;

    // Channel voice status nibbles
    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] CTRL       = 4'hB;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;

    // Controller numbers acted upon
    localparam logic [6:0] MOD_WHEEL     = 7'd1;
    localparam logic [6:0] ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] ALL_NOTES_OFF = 7'd123;

    // Synthesizer clocking used to size the pitch divider
    localparam int CLOCK_HZ      = 50_000_000;
    localparam int WAVETABLE_LEN = 256;
    localparam int NUM_NOTES     = 128;
    localparam int TICK_W        = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2
    } parse_state_e;

    // Deferred output effect carried through the pipeline stage
    typedef enum logic [1:0] {
        ACT_NONE     = 2'd0,
        ACT_NOTE_ON  = 2'd1,
        ACT_GATE_OFF = 2'd2,
        ACT_MOD      = 2'd3
    } action_e;

    typedef struct packed {
        action_e    kind;
        logic [7:0] value;
    } action_t;

    // Clocks per wavetable step minus one for an equal-tempered note (A4 = 440 Hz).
    // Only ever evaluated at elaboration to build ROM contents.
    function automatic logic [TICK_W-1:0] note_ticks(input int n);
        real f;
        real t;
        f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        t = real'(CLOCK_HZ) / (real'(WAVETABLE_LEN) * f);
        return TICK_W'($rtoi(t + 0.5) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_note_controller_rom.sv
`default_nettype none
// ============================================================================
//  Module      : note_tick_rom
//  Description : 128 x 24 synchronous-read note-to-ticks ROM, 1-cycle latency.
//                Output register resets to the entry for RESET_ADDR so the
//                pitch is valid in the very first cycle after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module note_tick_rom
    import midi_pkg::*;
#(
    parameter int RESET_ADDR = 69
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        i_addr,
    output logic [TICK_W-1:0] o_data
);

    localparam logic [TICK_W-1:0] c_RESET_TICKS = note_ticks(RESET_ADDR);

    logic [TICK_W-1:0] w_table [NUM_NOTES];
    logic [TICK_W-1:0] data_q;

    for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_rom
        localparam logic [TICK_W-1:0] c_TICKS = note_ticks(gi);
        assign w_table[gi] = c_TICKS;
    end

    // Registered table read
    always_ff @(posedge clk) begin
        if (rst) data_q <= c_RESET_TICKS;
        else     data_q <= w_table[i_addr];
    end

    assign o_data = data_q;

endmodule
`default_nettype wire

// File: rtl/midi_note_controller.sv
`default_nettype none
// ============================================================================
//  Module      : midi_note_controller
//  Description : MIDI channel-voice parser driving a monophonic note gate,
//                pitch divider and mod-wheel level for the wavetable synth.
//                Completing byte in cycle N -> currentNote at N+1, pitch,
//                gate and CC effects together at N+2.
//  Revision    : 1.0  initial release
// ============================================================================
module midi_note_controller
    import midi_pkg::*;
#(
    parameter int MIDI_CHANNEL = 0,
    parameter int OMNI         = 0,
    parameter int RESET_NOTE   = 69
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [7:0]        midiByte,
    input  logic              midiByteValid,
    output logic              isNoteOn,
    output logic [TICK_W-1:0] noteSampleTicks,
    output logic [7:0]        modulationValue,
    output logic [6:0]        currentNote
);

    parse_state_e state_q, state_d;
    logic [3:0]   rs_cmd_q, rs_cmd_d;
    logic [3:0]   rs_chan_q, rs_chan_d;
    logic         rs_valid_q, rs_valid_d;
    logic [6:0]   d1_q, d1_d;
    action_t      act_q, act_d;
    logic [6:0]   note_q, note_d;
    logic         gate_q, gate_d;
    logic [7:0]   mod_q, mod_d;

    logic         w_msg_done;
    logic [6:0]   w_msg_d1;
    logic [6:0]   w_msg_d2;
    logic         w_chan_ok;

    // Byte classification and message assembly
    always_comb begin
        state_d    = state_q;
        rs_cmd_d   = rs_cmd_q;
        rs_chan_d  = rs_chan_q;
        rs_valid_d = rs_valid_q;
        d1_d       = d1_q;
        w_msg_done = 1'b0;
        w_msg_d1   = d1_q;
        w_msg_d2   = 7'd0;
        if (midiByteValid) begin
            if (midiByte[7:3] == 5'b11111) begin
                // Real-time bytes may land anywhere; leave parsing untouched
            end else if (midiByte[7:4] == 4'hF) begin
                rs_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end else if (midiByte[7]) begin
                rs_cmd_d   = midiByte[7:4];
                rs_chan_d  = midiByte[3:0];
                rs_valid_d = 1'b1;
                state_d    = ST_WAIT_D1;
            end else if (state_q == ST_WAIT_D2) begin
                w_msg_done = 1'b1;
                w_msg_d2   = midiByte[6:0];
                state_d    = ST_WAIT_D1;
            end else if (rs_valid_q) begin
                // WAIT_D1, or IDLE under running status: this is the first data byte
                d1_d = midiByte[6:0];
                if (rs_cmd_q == PROG || rs_cmd_q == CHAN_PRESS) begin
                    w_msg_done = 1'b1;
                    w_msg_d1   = midiByte[6:0];
                    state_d    = ST_WAIT_D1;
                end else begin
                    state_d = ST_WAIT_D2;
                end
            end
        end
    end

    assign w_chan_ok = (OMNI != 0) || (rs_chan_q == 4'(MIDI_CHANNEL));

    // Decode a completed message into a note update and a deferred action
    always_comb begin
        act_d  = '{kind: ACT_NONE, value: 8'd0};
        note_d = note_q;
        if (w_msg_done && w_chan_ok) begin
            case (rs_cmd_q)
                NOTE_ON: begin
                    if (w_msg_d2 != 7'd0) begin
                        act_d.kind = ACT_NOTE_ON;
                        note_d     = w_msg_d1;
                    end else if (w_msg_d1 == note_q) begin
                        act_d.kind = ACT_GATE_OFF;
                    end
                end
                NOTE_OFF: begin
                    if (w_msg_d1 == note_q) act_d.kind = ACT_GATE_OFF;
                end
                CTRL: begin
                    if (w_msg_d1 == MOD_WHEEL) begin
                        act_d.kind  = ACT_MOD;
                        act_d.value = {w_msg_d2, w_msg_d2[6]};
                    end else if (w_msg_d1 == ALL_SOUND_OFF || w_msg_d1 == ALL_NOTES_OFF) begin
                        act_d.kind = ACT_GATE_OFF;
                    end
                end
                default: ;
            endcase
        end
    end

    // Apply the deferred action in step with the ROM read of the new note
    always_comb begin
        gate_d = gate_q;
        mod_d  = mod_q;
        case (act_q.kind)
            ACT_NOTE_ON:  gate_d = 1'b1;
            ACT_GATE_OFF: gate_d = 1'b0;
            ACT_MOD:      mod_d  = act_q.value;
            default:      ;
        endcase
    end

    // Parser FSM, running status and output pipeline registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rs_cmd_q   <= 4'd0;
            rs_chan_q  <= 4'd0;
            rs_valid_q <= 1'b0;
            d1_q       <= 7'd0;
            act_q      <= '{kind: ACT_NONE, value: 8'd0};
            note_q     <= 7'(RESET_NOTE);
            gate_q     <= 1'b0;
            mod_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            rs_cmd_q   <= rs_cmd_d;
            rs_chan_q  <= rs_chan_d;
            rs_valid_q <= rs_valid_d;
            d1_q       <= d1_d;
            act_q      <= act_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
            mod_q      <= mod_d;
        end
    end

    note_tick_rom #(
        .RESET_ADDR (RESET_NOTE)
    ) u_rom (
        .clk    (CLOCK_50),
        .rst    (reset),
        .i_addr (note_q),
        .o_data (noteSampleTicks)
    );

    assign isNoteOn        = gate_q;
    assign modulationValue = mod_q;
    assign currentNote     = note_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_note_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_midi_note_controller
//  Description : Scoreboard bench for midi_note_controller. Two instances
//                (channel 0 strict, OMNI) share one byte stream; a reference
//                model predicts outputs which a monitor compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_midi_note_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mbyte;
    logic       mvalid;

    logic        gate_o  [2];
    logic [23:0] ticks_o [2];
    logic [7:0]  mod_o   [2];
    logic [6:0]  note_o  [2];

    always #10 clk = ~clk;

    midi_note_controller #(.MIDI_CHANNEL(0), .OMNI(0), .RESET_NOTE(69)) u_dut0 (
        .CLOCK_50(clk), .reset(rst), .midiByte(mbyte), .midiByteValid(mvalid),
        .isNoteOn(gate_o[0]), .noteSampleTicks(ticks_o[0]),
        .modulationValue(mod_o[0]), .currentNote(note_o[0]));

    midi_note_controller #(.MIDI_CHANNEL(5), .OMNI(1), .RESET_NOTE(69)) u_dut1 (
        .CLOCK_50(clk), .reset(rst), .midiByte(mbyte), .midiByteValid(mvalid),
        .isNoteOn(gate_o[1]), .noteSampleTicks(ticks_o[1]),
        .modulationValue(mod_o[1]), .currentNote(note_o[1]));

    typedef struct { int due; int inst; int val; } note_exp_t;
    typedef struct { int due; int inst; int gate; int ticks; int mod; } out_exp_t;

    note_exp_t q_note[$];
    out_exp_t  q_out[$];

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, one per instance
    int m_rs[2], m_cnt[2], m_d1[2], m_note[2], m_gate[2], m_mod[2];

    always @(posedge clk) cyc++;

    function automatic int ref_ticks(input int n);
        real f;
        f = 440.0 * (2.0 ** (real'(n - 69) / 12.0));
        return $rtoi(50.0e6 / (256.0 * f) + 0.5) - 1;
    endfunction

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", name, inst, cyc, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rs[i] = -1; m_cnt[i] = 0; m_d1[i] = 0;
            m_note[i] = 69; m_gate[i] = 0; m_mod[i] = 0;
        end
    endfunction

    function automatic void model_exec(input int i, input int st, input int d1, input int d2);
        int hi;
        hi = st / 16;
        if (i == 0 && (st % 16) != 0) return;   // instance 0 listens on channel 0 only
        if (hi == 9 && d2 != 0) begin
            m_note[i] = d1; m_gate[i] = 1;
        end else if (hi == 8 || hi == 9) begin
            if (d1 == m_note[i]) m_gate[i] = 0;
        end else if (hi == 11) begin
            if (d1 == 1) m_mod[i] = d2 * 2 + d2 / 64;
            else if (d1 == 120 || d1 == 123) m_gate[i] = 0;
        end
    endfunction

    function automatic void model_byte(input int i, input int by);
        int need;
        if (by >= 'hF8) return;
        if (by >= 'hF0) begin m_rs[i] = -1; m_cnt[i] = 0; return; end
        if (by >= 'h80) begin m_rs[i] = by; m_cnt[i] = 0; return; end
        if (m_rs[i] < 0) return;
        need = (m_rs[i] / 16 == 12 || m_rs[i] / 16 == 13) ? 1 : 2;
        if (m_cnt[i] == 0) m_d1[i] = by;
        m_cnt[i]++;
        if (m_cnt[i] == need) begin
            m_cnt[i] = 0;
            model_exec(i, m_rs[i], m_d1[i], by);
        end
    endfunction

    // One cycle of stimulus; expectations are queued for the monitor
    task automatic step(input bit valid, input logic [7:0] by);
        @(negedge clk);
        mvalid = valid;
        mbyte  = by;
        for (int i = 0; i < 2; i++) begin
            if (valid) model_byte(i, int'(by));
            q_note.push_back('{due: cyc + 1, inst: i, val: m_note[i]});
            q_out.push_back('{due: cyc + 2, inst: i, gate: m_gate[i],
                              ticks: ref_ticks(m_note[i]), mod: m_mod[i]});
        end
    endtask

    task automatic send(input logic [7:0] by);
        step(1'b1, by);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) begin
            chk("reset_gate",  i, int'(gate_o[i]),  0);
            chk("reset_note",  i, int'(note_o[i]),  69);
            chk("reset_ticks", i, int'(ticks_o[i]), 443);
            chk("reset_mod",   i, int'(mod_o[i]),   0);
        end
    endtask

    task automatic do_reset();
        repeat (3) begin
            @(negedge clk);
            mvalid = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_state();
    endtask

    // Scoreboard monitor: compares whatever expectations fall due this cycle
    always @(negedge clk) begin
        while (q_note.size() > 0 && q_note[0].due <= cyc) begin
            note_exp_t e;
            e = q_note.pop_front();
            chk("currentNote", e.inst, int'(note_o[e.inst]), e.val);
        end
        while (q_out.size() > 0 && q_out[0].due <= cyc) begin
            out_exp_t o;
            o = q_out.pop_front();
            chk("isNoteOn",        o.inst, int'(gate_o[o.inst]),  o.gate);
            chk("noteSampleTicks", o.inst, int'(ticks_o[o.inst]), o.ticks);
            chk("modulationValue", o.inst, int'(mod_o[o.inst]),   o.mod);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int r;
        logic [7:0] by;
        rst = 1'b1; mvalid = 1'b0; mbyte = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        // Basic note on / off
        send(8'h90); send(8'h45); send(8'h64); idle(2);
        chk("on69_gate", 0, int'(gate_o[0]), 1);
        chk("on69_ticks", 0, int'(ticks_o[0]), 443);
        send(8'h80); send(8'h45); send(8'h00); idle(2);
        chk("off69_gate", 0, int'(gate_o[0]), 0);
        chk("off69_ticks", 0, int'(ticks_o[0]), 443);

        // Running status
        send(8'h90); send(8'h3C); send(8'h40); send(8'h3C); send(8'h00);
        send(8'h48); send(8'h7F); idle(2);
        chk("rs_note72", 0, int'(note_o[0]), 72);

        // Mismatched note off, then all notes off
        send(8'h90); send(8'h3C); send(8'h40);
        send(8'h80); send(8'h40); send(8'h00); idle(2);
        chk("mismatch_off_gate", 0, int'(gate_o[0]), 1);
        send(8'hB0); send(8'h7B); send(8'h00); idle(2);
        chk("all_off_gate", 0, int'(gate_o[0]), 0);

        // Mod wheel scaling
        send(8'hB0); send(8'h01); send(8'h00);
        send(8'hB0); send(8'h01); send(8'h40); idle(2);
        chk("mod64", 0, int'(mod_o[0]), 129);
        send(8'hB0); send(8'h01); send(8'h7F);
        send(8'hB0); send(8'h07); send(8'h7F); idle(2);
        chk("mod127", 0, int'(mod_o[0]), 255);

        // Real-time interleaving and SysEx abort
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hF8); send(8'h50);
        send(8'h90); send(8'h3C); send(8'hF0); send(8'h50); send(8'h50); idle(2);

        // Foreign channel: ignored by instance 0, accepted by OMNI instance
        send(8'h91); send(8'h3E); send(8'h40); idle(2);

        // ROM extremes
        send(8'h90); send(8'h00); send(8'h40); idle(2);
        chk("ticks_n0", 0, int'(ticks_o[0]), 23888);
        send(8'h7F); send(8'h40); idle(2);
        chk("ticks_n127", 0, int'(ticks_o[0]), 15);

        // Reset between D1 and D2, then a lone data byte
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h40); idle(3);

        // Randomized byte stream, including back-to-back strobes
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                step(1'b0, 8'h00);
            end else if (r < 16) begin
                send(8'(8'hF8 + $urandom_range(0, 7)));
            end else if (r < 18) begin
                send(8'(8'hF0 + $urandom_range(0, 7)));
            end else if (r < 34) begin
                case ($urandom_range(0, 6))
                    0: by = 8'h80; 1, 2: by = 8'h90; 3: by = 8'hB0;
                    4: by = 8'hC0; 5: by = 8'hD0; default: by = 8'hE0;
                endcase
                if ($urandom_range(0, 9) < 3) by[3:0] = 4'($urandom_range(1, 15));
                send(by);
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: by = 8'(60 + 2 * $urandom_range(0, 2));
                    4: by = 8'h00;
                    5: by = 8'h01;
                    6: by = ($urandom_range(0, 1) == 0) ? 8'd120 : 8'd123;
                    7: by = 8'h7F;
                    default: by = 8'($urandom_range(0, 127));
                endcase
                send(by);
            end
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/midi_note_controller.md
Name: midi_note_controller

Overview:
- Upstream control stage for the wavetable synthesizer.
- Consumes the byte stream from the MIDI UART receiver and parses channel voice messages.
- Drives the synthesizer's monophonic note gate (isNoteOn), pitch divider (noteSampleTicks) and mod-wheel level (modulationValue).
- Pitch divider comes from a 128-entry note-to-ticks ROM, sized for the 256-entry wavetable clocked at 50 MHz.

Parameters:
- MIDI_CHANNEL, 0, receive channel 0-15 (matched against status low nibble).
- OMNI, 0, 1 = accept all channels and ignore MIDI_CHANNEL.
- RESET_NOTE, 69, note loaded into currentNote/noteSampleTicks at reset.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- midiByte  in  8  received MIDI byte.
- midiByteValid  in  1  one-cycle strobe; midiByte valid; at most one per cycle, no backpressure.
- isNoteOn  out  1  gate to synthesizer.
- noteSampleTicks  out  24  clocks-per-wavetable-step minus 1 for currentNote.
- modulationValue  out  8  mod wheel, 8-bit scaled.
- currentNote  out  7  last accepted note number.

Behaviour:
- Clock and reset: one clock, CLOCK_50; reset is synchronous and active-high.
- Reset values:
  - isNoteOn=0, currentNote=RESET_NOTE, noteSampleTicks=ROM[RESET_NOTE] (443 for note 69), modulationValue=0.
  - Parser state IDLE, running status cleared.
  - Reset mid-message discards the partial message.
- Byte classes, evaluated only when midiByteValid=1:
  - 0xF8-0xFF real-time: ignored; parser state and running status untouched.
  - 0xF0-0xF7 system common/SysEx: clears running status, state->IDLE; following data bytes are discarded.
  - 0x80-0xEF channel status: latch as running status, state->WAIT_D1. A status byte in any state aborts the partial message.
  - 0x00-0x7F data byte:
    - In IDLE with running status valid: treated as D1.
    - In IDLE without running status: discarded.
- FSM IDLE/WAIT_D1/WAIT_D2:
  - WAIT_D1 + data: latch D1. For 0xC/0xD status, the message completes and state->WAIT_D1 (running status). For all other status, state->WAIT_D2.
  - WAIT_D2 + data: latch D2, message completes, state->WAIT_D1.
- Channel filter: a completed message with a non-matching channel is discarded, unless OMNI=1.
- Actions on a completed message:
  - 0x9n with D2!=0: currentNote=D1, isNoteOn=1.
  - 0x8n, or 0x9n with D2=0: if D1==currentNote then isNoteOn=0; else no change. noteSampleTicks is held so the synthesizer's release runs at the same pitch.
  - 0xBn D1=1 (mod wheel): modulationValue={D2,D2[6]} (0->0, 64->129, 127->255).
  - 0xBn D1=123 or 120 (all notes/sound off): isNoteOn=0.
  - All other messages: no output change.
- Timing:
  - Completing byte strobe in cycle N.
  - currentNote registered at N+1 (ROM address).
  - noteSampleTicks and isNoteOn updated together at N+2. The gate never precedes the new pitch.
  - Note-off and CC outputs are also delayed to N+2, so all message effects keep their order.
  - Back-to-back strobes every cycle must be handled: the pipeline carries one pending action per stage.
- ROM content: ticks[n] = round(50e6 / (256 * f(n))) - 1, with f(n) = 440 * 2^((n-69)/12).
  - Example values: n=0 -> 23888, n=69 -> 443, n=127 -> 15.
  - All values fit in 24 bits.

Decomposition:
- midi_pkg:
  - Status nibble constants NOTE_OFF=0x8, NOTE_ON=0x9, CTRL=0xB, PROG=0xC, CHAN_PRESS=0xD.
  - CC numbers MOD_WHEEL=1, ALL_SOUND_OFF=120, ALL_NOTES_OFF=123.
  - Parser state enum.
  - CLOCK_HZ=50_000_000, WAVETABLE_LEN=256.
- Sub-module note_tick_rom: 128x24 synchronous-read ROM, 7-bit address, 1-cycle latency, init file generated from the formula above.

Test Plan:
- Reset, then 0x90 0x45 0x64 -> at N+2: isNoteOn=1, currentNote=69, noteSampleTicks=443. 0x80 0x45 0x00 -> isNoteOn=0, noteSampleTicks stays 443.
- Running status: 0x90 0x3C 0x40, then 0x3C 0x00 -> isNoteOn 1 then 0. Then 0x48 0x7F with no new status -> isNoteOn=1, currentNote=72, noteSampleTicks=ROM[72].
- Mismatched note-off: note-on 60, then 0x80 0x40 0x00 -> isNoteOn stays 1. 0xB0 0x7B 0x00 -> isNoteOn=0.
- Mod wheel: 0xB0 0x01 0x00/0x40/0x7F -> modulationValue 0/129/255. 0xB0 0x07 0x7F -> unchanged.
- Interleaving: 0x90 0xF8 0x3C 0xF8 0x50 -> note 60 on, real-time ignored. 0x90 0x3C 0xF0 0x50 -> no change; later 0x50 discarded (no running status).
- Channel/reset:
  - MIDI_CHANNEL=0: 0x91 0x3C 0x40 -> ignored.
  - OMNI=1: same message accepted.
  - reset asserted between D1 and D2 -> outputs return to reset values; a following lone data byte is discarded.
